// File: rtl/alu_writeback_buffer.sv
// alu_writeback_buffer: show-ahead FIFO between ALU completion and the
// register-file write port; also holds the architectural Z flag.
//
// Ports:
//   clk, reset       clock, async active-low reset
//   in_*             ALU result push side (valid/ready)
//   wr_*             register-file write side (valid/ready, show-ahead)
//   z_flag_q         architectural Z flag, updated at push time
//   flush            synchronous discard of all entries
//   count            occupied entries, 0..DEPTH
//   overflow         sticky: push offered while full
module alu_writeback_buffer #(
    parameter int DATA_LEN = 16,
    parameter int DEST_LEN = 4,
    parameter int DEPTH    = 4,
    parameter int PTR_LEN  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] in_data,
    input  logic                in_z,
    input  logic                in_upd_z,
    input  logic [DEST_LEN-1:0] in_dest,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [DATA_LEN-1:0] wr_data,
    output logic [DEST_LEN-1:0] wr_dest,
    output logic                z_flag_q,
    input  logic                flush,
    output logic [PTR_LEN:0]    count,
    output logic                overflow
);

    logic [DATA_LEN-1:0] data_mem_q [DEPTH];
    logic [DEST_LEN-1:0] dest_mem_q [DEPTH];

    logic [PTR_LEN-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_LEN-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_LEN:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               z_flag_d;
    logic               push, pop;

    assign in_ready = (count_q != (PTR_LEN+1)'(DEPTH));
    assign wr_valid = (count_q != '0);
    assign count    = count_q;
    assign overflow = overflow_q;

    // Outputs read 0 while empty so reset drives them low without
    // having to clear the storage array.
    assign wr_data = wr_valid ? data_mem_q[rd_ptr_q] : '0;
    assign wr_dest = wr_valid ? dest_mem_q[rd_ptr_q] : '0;

    // Flush wins over both sides of the handshake.
    assign push = in_valid && in_ready && !flush;
    assign pop  = wr_valid && wr_ready && !flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        z_flag_d   = z_flag_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_LEN'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_LEN'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (PTR_LEN+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (PTR_LEN+1)'(1);
            end
            if (push && in_upd_z) begin
                z_flag_d = in_z;
            end
            if (in_valid && !in_ready) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            z_flag_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            z_flag_q   <= z_flag_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= in_data;
            dest_mem_q[wr_ptr_q] <= in_dest;
        end
    end

endmodule

// File: tb/tb_alu_writeback_buffer.sv
// tb_alu_writeback_buffer: directed stimulus with a queue scoreboard;
// the monitor checks each entry the register file accepts.
module tb_alu_writeback_buffer;

    localparam int DL = 16;
    localparam int DS = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DL-1:0] in_data = '0;
    logic          in_z = 1'b0;
    logic          in_upd_z = 1'b0;
    logic [DS-1:0] in_dest = '0;
    logic          wr_valid;
    logic          wr_ready = 1'b0;
    logic [DL-1:0] wr_data;
    logic [DS-1:0] wr_dest;
    logic          z_flag_q;
    logic          flush = 1'b0;
    logic [2:0]    count;
    logic          overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DL+DS-1:0] sb[$];

    alu_writeback_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_z     (in_z),
        .in_upd_z (in_upd_z),
        .in_dest  (in_dest),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_dest  (wr_dest),
        .z_flag_q (z_flag_q),
        .flush    (flush),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one push for a cycle; queue it only when it should be accepted.
    task automatic offer(input logic [DL-1:0] d, input logic [DS-1:0] dst,
                         input logic z, input logic upd, input bit accept);
        in_valid = 1'b1;
        in_data  = d;
        in_dest  = dst;
        in_z     = z;
        in_upd_z = upd;
        if (accept) sb.push_back({d, dst});
        step();
        in_valid = 1'b0;
        in_upd_z = 1'b0;
    endtask

    // Monitor: a handshake visible mid-cycle completes at the next edge.
    always @(negedge clk) begin
        if (reset && !flush && wr_valid && wr_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got %0h/%0h expected none",
                         wr_data, wr_dest);
            end else begin
                logic [DL+DS-1:0] e;
                e = sb.pop_front();
                if ({wr_data, wr_dest} !== e) begin
                    n_fail++;
                    $display("FAIL sb_data: got %0h/%0h expected %0h/%0h",
                             wr_data, wr_dest, e[DL+DS-1:DS], e[DS-1:0]);
                end
            end
        end
    end

    initial begin
        #2;
        chk("rst_wr_valid", 32'(wr_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_wr_dest", 32'(wr_dest), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_z", 32'(z_flag_q), 0);
        step();
        reset = 1'b1;
        #2;
        chk("rst_in_ready", 32'(in_ready), 1);
        step();

        // Single push, held at the output
        offer(16'h0005, 4'd3, 1'b0, 1'b1, 1'b1);
        chk("t1_wr_valid", 32'(wr_valid), 1);
        chk("t1_wr_data", 32'(wr_data), 32'h5);
        chk("t1_wr_dest", 32'(wr_dest), 3);
        chk("t1_count", 32'(count), 1);
        chk("t1_z", 32'(z_flag_q), 0);
        step();
        chk("t1_hold_data", 32'(wr_data), 32'h5);
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;
        chk("t1_empty", 32'(count), 0);

        // Fill, overflow, drain
        for (int i = 1; i <= 4; i++)
            offer(DL'(i), DS'(i), 1'b0, 1'b0, 1'b1);
        chk("t2_count_full", 32'(count), 4);
        chk("t2_in_ready", 32'(in_ready), 0);
        chk("t2_ovf_before", 32'(overflow), 0);
        offer(16'h0009, 4'd9, 1'b0, 1'b0, 1'b0);
        chk("t2_overflow", 32'(overflow), 1);
        chk("t2_count_stay", 32'(count), 4);
        wr_ready = 1'b1;
        repeat (4) step();
        wr_ready = 1'b0;
        chk("t2_drained", 32'(count), 0);
        chk("t2_wr_valid", 32'(wr_valid), 0);
        chk("t2_sb_empty", 32'(sb.size()), 0);

        // Streaming with pointer wrap
        wr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(16'h0100 + DL'(i), DS'(i), 1'b0, 1'b0, 1'b1);
            chk("t3_count_steady", 32'(count), 1);
            in_valid = 1'b1;
        end
        in_valid = 1'b0;
        step();
        chk("t3_drained", 32'(count), 0);
        chk("t3_sb_empty", 32'(sb.size()), 0);

        // Z flag updates
        offer(16'h0000, 4'd1, 1'b1, 1'b1, 1'b1);
        chk("t4_z_set", 32'(z_flag_q), 1);
        offer(16'h0011, 4'd2, 1'b0, 1'b0, 1'b1);
        chk("t4_z_keep", 32'(z_flag_q), 1);
        offer(16'h0022, 4'd3, 1'b0, 1'b1, 1'b1);
        chk("t4_z_clr", 32'(z_flag_q), 0);
        step();
        wr_ready = 1'b0;
        chk("t4_sb_empty", 32'(sb.size()), 0);

        // Flush with count 3, push and pop offered
        for (int i = 0; i < 3; i++)
            offer(16'h0A00 + DL'(i), 4'd5, 1'b0, 1'b0, 1'b1);
        chk("t5_count3", 32'(count), 3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        in_z     = 1'b1;
        in_upd_z = 1'b1;
        wr_ready = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_upd_z = 1'b0;
        wr_ready = 1'b0;
        sb.delete();
        chk("t5_count", 32'(count), 0);
        chk("t5_wr_valid", 32'(wr_valid), 0);
        chk("t5_overflow", 32'(overflow), 1);
        chk("t5_z", 32'(z_flag_q), 0);

        // Async reset mid-cycle with count 2
        offer(16'h0031, 4'd1, 1'b1, 1'b1, 1'b1);
        offer(16'h0032, 4'd2, 1'b0, 1'b0, 1'b1);
        chk("t6_count2", 32'(count), 2);
        chk("t6_z_pre", 32'(z_flag_q), 1);
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("t6_wr_valid", 32'(wr_valid), 0);
        chk("t6_count", 32'(count), 0);
        chk("t6_z", 32'(z_flag_q), 0);
        chk("t6_overflow", 32'(overflow), 0);
        chk("t6_wr_data", 32'(wr_data), 0);
        #1;
        reset = 1'b1;
        step();
        offer(16'h0077, 4'd7, 1'b0, 1'b0, 1'b1);
        chk("t6_valid_after", 32'(wr_valid), 1);
        chk("t6_data_after", 32'(wr_data), 32'h77);
        chk("t6_dest_after", 32'(wr_dest), 7);
        wr_ready = 1'b1;
        step();
        wr_ready = 1'b0;

        // Flush while full and offered: no overflow from the discarded push
        for (int i = 0; i < 4; i++)
            offer(16'h0E00 + DL'(i), 4'd6, 1'b0, 1'b0, 1'b1);
        chk("t7_in_ready", 32'(in_ready), 0);
        flush    = 1'b1;
        in_valid = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        chk("t7_overflow", 32'(overflow), 0);
        chk("t7_count", 32'(count), 0);
        chk("t7_in_ready_after", 32'(in_ready), 1);

        step();
        chk("end_sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
